// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache between a 32-bit
// processor port and a 128-bit-block L2; hits resolve in the request cycle.
module l1_dcache #(
  parameter int ENTRY       = 8,
  parameter int WORDPERDATA = 4,
  parameter int TAGLEN      = 25,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      proc_read,
  input  logic                      proc_write,
  input  logic [29:0]               proc_addr,
  input  logic [31:0]               proc_wdata,
  output logic [31:0]               proc_rdata,
  output logic                      proc_stall,
  output logic                      l2_read,
  output logic                      l2_write,
  output logic [29:0]               l2_addr,
  output logic [32*WORDPERDATA-1:0] l2_wdata,
  input  logic [32*WORDPERDATA-1:0] l2_rdata,
  input  logic                      l2_ready
);

  localparam int BLOCK_W = 32 * WORDPERDATA;
  localparam int IDX_W   = $clog2(ENTRY);
  localparam int OFF_W   = $clog2(WORDPERDATA);
  localparam int CNT_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE, GAP} state_t;

  state_t state, state_nxt;
  state_t ret, ret_nxt;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;

  logic [BLOCK_W-1:0] data_mem [ENTRY];
  logic [TAGLEN-1:0]  tag_mem  [ENTRY];
  logic [ENTRY-1:0]   valid;
  logic [ENTRY-1:0]   dirty;

  logic               l2_read_nxt, l2_write_nxt;
  logic [29:0]        l2_addr_nxt;
  logic [BLOCK_W-1:0] l2_wdata_nxt;

  logic [IDX_W-1:0]   idx;
  logic [OFF_W-1:0]   word_sel;
  logic [TAGLEN-1:0]  req_tag;
  logic [29:0]        blk_addr;
  logic [31:0]        cur_word;
  logic               req, hit;
  logic               write_hit, fill, wb_done;

  assign idx      = proc_addr[OFF_W +: IDX_W];
  assign word_sel = proc_addr[OFF_W-1:0];
  assign req_tag  = proc_addr[29 -: TAGLEN];
  assign blk_addr = {proc_addr[29:OFF_W], {OFF_W{1'b0}}};
  assign cur_word = data_mem[idx][{word_sel, 5'd0} +: 32];
  assign req      = proc_read | proc_write;
  assign hit      = valid[idx] && (tag_mem[idx] == req_tag);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= COMPARE;
      ret     <= COMPARE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      ret     <= ret_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ret_nxt      = ret;
    gap_cnt_nxt  = gap_cnt;
    l2_read_nxt  = l2_read;
    l2_write_nxt = l2_write;
    l2_addr_nxt  = l2_addr;
    l2_wdata_nxt = l2_wdata;
    proc_stall   = 1'b0;
    proc_rdata   = '0;
    write_hit    = 1'b0;
    fill         = 1'b0;
    wb_done      = 1'b0;
    case (state)
      COMPARE: begin
        if (req) begin
          if (hit) begin
            write_hit = proc_write;
            if (proc_read) proc_rdata = cur_word;
          end else begin
            proc_stall = 1'b1;
            if (valid[idx] && dirty[idx]) begin
              l2_write_nxt = 1'b1;
              l2_addr_nxt  = {tag_mem[idx], idx, {OFF_W{1'b0}}};
              l2_wdata_nxt = data_mem[idx];
              state_nxt    = WRITEBACK;
            end else begin
              l2_read_nxt = 1'b1;
              l2_addr_nxt = blk_addr;
              state_nxt   = ALLOCATE;
            end
          end
        end
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        if (l2_ready) begin
          l2_write_nxt = 1'b0;
          wb_done      = 1'b1;
          state_nxt    = GAP;
          ret_nxt      = ALLOCATE;
          gap_cnt_nxt  = '0;
        end
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        if (l2_ready) begin
          l2_read_nxt = 1'b0;
          fill        = 1'b1;
          state_nxt   = GAP;
          ret_nxt     = COMPARE;
          gap_cnt_nxt = '0;
        end
      end
      GAP: begin
        // l2_ready is deliberately ignored here so a late pulse cannot ack the next request
        proc_stall = 1'b1;
        if (gap_cnt == CNT_W'(GAP_CYCLES - 1)) begin
          gap_cnt_nxt = '0;
          state_nxt   = ret;
          if (ret == ALLOCATE) begin
            l2_read_nxt = 1'b1;
            l2_addr_nxt = blk_addr;
          end
        end else begin
          gap_cnt_nxt = gap_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = COMPARE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      l2_read  <= 1'b0;
      l2_write <= 1'b0;
      l2_addr  <= '0;
      l2_wdata <= '0;
    end else begin
      l2_read  <= l2_read_nxt;
      l2_write <= l2_write_nxt;
      l2_addr  <= l2_addr_nxt;
      l2_wdata <= l2_wdata_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (fill) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
      if (wb_done)   dirty[idx] <= 1'b0;
      if (write_hit) dirty[idx] <= 1'b1;
    end
  end

  // Line payload carries no reset; valid bits alone decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill) begin
        data_mem[idx] <= l2_rdata;
        tag_mem[idx]  <= req_tag;
      end else if (write_hit) begin
        data_mem[idx][{word_sel, 5'd0} +: 32] <= proc_wdata;
      end
    end
  end

endmodule

// File: tb/tb_l1_dcache.sv
// Scoreboard bench for l1_dcache: expected L2 requests and load data are queued
// per access and checked as the cache issues them, with a latency-driven L2 model.
module tb_l1_dcache;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         proc_read = 1'b0, proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         l2_read, l2_write;
  logic [29:0]  l2_addr;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata = '0;
  logic         l2_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           wr;
    logic [29:0]  addr;
    logic [127:0] data;
  } l2_req_t;

  l2_req_t      exp_l2 [$];
  logic [31:0]  exp_rd [$];
  logic [127:0] l2mem [logic [29:0]];

  localparam logic [127:0] IDLE_DATA  = {4{32'hBADC0DE5}};
  localparam logic [127:0] STALE_DATA = {4{32'hBAADF00D}};

  l1_dcache dut (
    .clk(clk), .reset(reset),
    .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .proc_stall(proc_stall),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_ready(l2_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic [29:0] a);
    logic [31:0] b;
    b = {2'b00, a} ^ 32'hA5000000;
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  function automatic logic [127:0] mem_rd(input logic [29:0] a);
    if (l2mem.exists(a)) return l2mem[a];
    return pat(a);
  endfunction

  task automatic push_l2(input bit wr, input logic [29:0] a, input logic [127:0] d);
    l2_req_t e;
    e.wr = wr; e.addr = a; e.data = d;
    exp_l2.push_back(e);
  endtask

  // Holds one processor request until the stall drops, serving L2 with 'lat' cycles of latency.
  task automatic run_access(input logic rd, input logic wr, input logic [29:0] addr,
                            input logic [31:0] wdata, input int lat, input bit stale,
                            output int stalls);
    bit          active = 0;
    bit          done = 0;
    int          cd = 0;
    int          gap_left = 0;
    logic [29:0] last_addr = '0;
    l2_req_t     e;
    logic [31:0] er;
    stalls = 0;
    @(negedge clk);
    proc_read = rd; proc_write = wr; proc_addr = addr; proc_wdata = wdata;
    for (int c = 0; c < 300 && !done; c++) begin
      if (c != 0) @(negedge clk);
      l2_ready = 1'b0;
      l2_rdata = IDLE_DATA;
      checks++;
      if (l2_read && l2_write) begin
        errors++;
        $display("FAIL l2_exclusive: l2_read=%b l2_write=%b, required not both high", l2_read, l2_write);
      end
      if (!active && (l2_read || l2_write)) begin
        checks++;
        if (exp_l2.size() == 0) begin
          errors++;
          $display("FAIL l2_unexpected: wr=%b addr=%h, required no request", l2_write, l2_addr);
        end else begin
          e = exp_l2.pop_front();
          if (l2_write !== e.wr || l2_addr !== e.addr || (e.wr && l2_wdata !== e.data)) begin
            errors++;
            $display("FAIL l2_request: wr=%b addr=%h wdata=%h, required wr=%b addr=%h wdata=%h",
                     l2_write, l2_addr, l2_wdata, e.wr, e.addr, e.data);
          end
        end
        active = 1; cd = lat;
      end
      if (active) begin
        cd--;
        if (cd <= 0) begin
          if (l2_write) l2mem[l2_addr] = l2_wdata;
          else          l2_rdata = mem_rd(l2_addr);
          l2_ready = 1'b1;
          active = 0; gap_left = 2; last_addr = l2_addr;
        end
      end else if (gap_left > 0) begin
        gap_left--;
        if (stale) begin
          l2_ready = 1'b1;
          l2_rdata = STALE_DATA;
        end
        checks++;
        if (l2_read !== 1'b0 || l2_write !== 1'b0 || l2_addr !== last_addr) begin
          errors++;
          $display("FAIL gap_hold: rd=%b wr=%b addr=%h, required 0 0 %h", l2_read, l2_write, l2_addr, last_addr);
        end
      end
      #1;
      if (!proc_stall) begin
        done = 1;
        if (rd && !wr) begin
          checks++;
          er = (exp_rd.size() != 0) ? exp_rd.pop_front() : 32'hXXXXXXXX;
          if (proc_rdata !== er) begin
            errors++;
            $display("FAIL load_data: addr=%h got %h, required %h", addr, proc_rdata, er);
          end
        end
      end else begin
        stalls++;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_timeout: addr=%h still stalled, required completion", addr);
    end
    checks++;
    if (exp_l2.size() != 0) begin
      errors++;
      $display("FAIL l2_missing: %0d expected requests not issued, required 0", exp_l2.size());
      exp_l2.delete();
    end
  endtask

  task automatic check_stalls(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: stall cycles %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (proc_stall !== 1'b0 || proc_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_proc: stall=%b rdata=%h, required 0 0", proc_stall, proc_rdata);
    end
    checks++;
    if (l2_read !== 1'b0 || l2_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_l2_req: rd=%b wr=%b, required 0 0", l2_read, l2_write);
    end
    checks++;
    if (l2_addr !== 30'h0 || l2_wdata !== 128'h0) begin
      errors++;
      $display("FAIL reset_l2_data: addr=%h wdata=%h, required 0 0", l2_addr, l2_wdata);
    end
  endtask

  task automatic test_cold_read();
    int s;
    l2mem[30'h4] = 128'h44444444_33333333_22222222_11111111;
    push_l2(0, 30'h4, '0);
    exp_rd.push_back(32'h22222222);
    run_access(1, 0, 30'h5, 32'h0, 5, 0, s);
    check_stalls("cold_miss_stall", s, 1 + 5 + 2);
  endtask

  task automatic test_read_hit();
    int s;
    exp_rd.push_back(32'h11111111);
    run_access(1, 0, 30'h4, 32'h0, 5, 0, s);
    check_stalls("read_hit_stall", s, 0);
  endtask

  task automatic test_write_conflict();
    int s;
    run_access(0, 1, 30'h6, 32'hDEADBEEF, 3, 0, s);
    check_stalls("write_hit_stall", s, 0);
    push_l2(1, 30'h4, 128'h44444444_DEADBEEF_22222222_11111111);
    push_l2(0, 30'h24, '0);
    exp_rd.push_back(pat(30'h24) >> 0);
    run_access(1, 0, 30'h24, 32'h0, 3, 0, s);
    check_stalls("dirty_miss_stall", s, 1 + 3 + 2 + 3 + 2);
  endtask

  task automatic test_stale_ready();
    int s;
    logic [127:0] p;
    push_l2(0, 30'h4, '0);
    exp_rd.push_back(32'hDEADBEEF);
    run_access(1, 0, 30'h6, 32'h0, 3, 1, s);
    check_stalls("stale_gap_stall", s, 1 + 3 + 2);
    @(negedge clk);
    proc_read = 1'b0; proc_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      l2_ready = (i == 1 || i == 2);
      l2_rdata = STALE_DATA;
      #1;
      checks++;
      if (l2_read !== 1'b0 || l2_write !== 1'b0 || proc_stall !== 1'b0 || proc_rdata !== 32'h0) begin
        errors++;
        $display("FAIL stale_idle: rd=%b wr=%b stall=%b rdata=%h, required 0 0 0 0",
                 l2_read, l2_write, proc_stall, proc_rdata);
      end
    end
    exp_rd.push_back(32'hDEADBEEF);
    run_access(1, 0, 30'h6, 32'h0, 3, 0, s);
    check_stalls("stale_line_kept", s, 0);
    p = pat(30'h24);
    exp_rd.push_back(p[63:32]);
    push_l2(0, 30'h24, '0);
    run_access(1, 0, 30'h25, 32'h0, 2, 0, s);
    check_stalls("stale_refill_stall", s, 1 + 2 + 2);
    push_l2(0, 30'h4, '0);
    exp_rd.push_back(32'h11111111);
    run_access(1, 0, 30'h4, 32'h0, 2, 0, s);
    check_stalls("stale_clean_evict", s, 1 + 2 + 2);
  endtask

  task automatic test_read_write_together();
    int s;
    logic [127:0] p;
    run_access(1, 1, 30'h7, 32'h12345678, 2, 0, s);
    check_stalls("rw_hit_stall", s, 0);
    p = pat(30'h24);
    push_l2(1, 30'h4, 128'h12345678_DEADBEEF_22222222_11111111);
    push_l2(0, 30'h24, '0);
    exp_rd.push_back(p[127:96]);
    run_access(1, 0, 30'h27, 32'h0, 2, 0, s);
    check_stalls("rw_dirty_evict", s, 1 + 2 + 2 + 2 + 2);
  endtask

  task automatic test_back_to_back();
    int s;
    logic [127:0] p;
    p = pat(30'h24);
    exp_rd.push_back(p[31:0]);
    run_access(1, 0, 30'h24, 32'h0, 2, 0, s);
    check_stalls("b2b_hit0", s, 0);
    exp_rd.push_back(p[63:32]);
    run_access(1, 0, 30'h25, 32'h0, 2, 0, s);
    check_stalls("b2b_hit1", s, 0);
    run_access(0, 1, 30'h26, 32'hCAFEF00D, 2, 0, s);
    check_stalls("b2b_write", s, 0);
    exp_rd.push_back(32'hCAFEF00D);
    run_access(1, 0, 30'h26, 32'h0, 2, 0, s);
    check_stalls("b2b_readback", s, 0);
  endtask

  task automatic test_reset_allocate();
    int s;
    bit seen = 0;
    logic [127:0] p;
    @(negedge clk);
    proc_read = 1'b1; proc_write = 1'b0; proc_addr = 30'h48;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = l2_read;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_alloc_req: l2_read=%b, required 1 within 10 cycles", l2_read);
    end
    reset = 1'b1; proc_read = 1'b0;
    l2_ready = 1'b1; l2_rdata = STALE_DATA;
    @(posedge clk); #1;
    checks++;
    if (l2_read !== 1'b0 || proc_stall !== 1'b0 || proc_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_alloc_drop: rd=%b stall=%b rdata=%h, required 0 0 0", l2_read, proc_stall, proc_rdata);
    end
    @(negedge clk);
    reset = 1'b0; l2_ready = 1'b0; l2_rdata = IDLE_DATA;
    p = pat(30'h48);
    push_l2(0, 30'h48, '0);
    exp_rd.push_back(p[31:0]);
    run_access(1, 0, 30'h48, 32'h0, 2, 0, s);
    check_stalls("rst_alloc_remiss", s, 1 + 2 + 2);
    push_l2(0, 30'h24, '0);
    exp_rd.push_back(32'hCAFEF00D ^ 32'hCAFEF00D ^ pat(30'h24) >> 64);
    run_access(1, 0, 30'h26, 32'h0, 2, 0, s);
    check_stalls("rst_invalidated", s, 1 + 2 + 2);
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_read_hit();
    test_write_conflict();
    test_stale_ready();
    test_read_write_together();
    test_back_to_back();
    test_reset_allocate();
    @(negedge clk);
    proc_read = 1'b0; proc_write = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
